// File: rtl/sdram_arbit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : sdram_arbit                                                      |
// | Brief   : Grants the SDRAM command bus to init/refresh/write/read stages   |
// |           and muxes the selected stage onto the SDRAM pins.                |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module sdram_arbit #(
  parameter int TIMEOUT_CYC = 1023,
  parameter int DQ_W        = 16
) (
  input  logic            sclk,
  input  logic            s_rst,
  input  logic [3:0]      init_cmd,
  input  logic [12:0]     init_addr,
  input  logic            flag_init_end,
  input  logic            ref_req,
  output logic            ref_en,
  input  logic [3:0]      aref_cmd,
  input  logic [12:0]     aref_addr,
  input  logic            flag_ref_end,
  input  logic            wr_req,
  output logic            wr_en,
  input  logic [3:0]      wr_cmd,
  input  logic [12:0]     wr_addr,
  input  logic [1:0]      wr_bank,
  input  logic [DQ_W-1:0] wr_data,
  input  logic            flag_wr_end,
  input  logic            rd_req,
  output logic            rd_en,
  input  logic [3:0]      rd_cmd,
  input  logic [12:0]     rd_addr,
  input  logic [1:0]      rd_bank,
  input  logic            flag_rd_end,
  output logic            sdram_cke,
  output logic            sdram_cs_n,
  output logic            sdram_ras_n,
  output logic            sdram_cas_n,
  output logic            sdram_we_n,
  output logic [1:0]      sdram_bank,
  output logic [12:0]     sdram_addr,
  output logic [DQ_W-1:0] sdram_dq_out,
  output logic            sdram_dq_oe,
  output logic            err_timeout
);

  localparam int                 c_CNT_W  = $clog2(TIMEOUT_CYC + 1);
  localparam logic [c_CNT_W-1:0] c_TMO    = c_CNT_W'(TIMEOUT_CYC);
  localparam logic [c_CNT_W-1:0] c_TMO_M1 = c_CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]         c_NOP    = 4'b0111;

  typedef enum logic [4:0] {
    S_INIT  = 5'b00001,
    S_ARBIT = 5'b00010,
    S_AREF  = 5'b00100,
    S_WRITE = 5'b01000,
    S_READ  = 5'b10000
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               r_last_wr;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_err;
  logic               r_cke;
  logic               w_grant;
  logic [3:0]         w_cmd;

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      r_state   <= S_INIT;
      r_last_wr <= 1'b0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_cke     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cke   <= 1'b1;
      if (r_state == S_ARBIT && w_next == S_WRITE) r_last_wr <= 1'b1;
      if (r_state == S_ARBIT && w_next == S_READ)  r_last_wr <= 1'b0;
      // Timeout only flags a stuck stage; the grant itself is left running.
      if (w_next != r_state) begin
        r_cnt <= '0;
      end else if (w_grant) begin
        if (r_cnt != c_TMO) r_cnt <= r_cnt + 1'b1;
        if (r_cnt == c_TMO_M1) r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_INIT:  if (flag_init_end) w_next = S_ARBIT;
      S_ARBIT: begin
        if (ref_req)               w_next = S_AREF;
        else if (wr_req && rd_req) w_next = r_last_wr ? S_READ : S_WRITE;
        else if (wr_req)           w_next = S_WRITE;
        else if (rd_req)           w_next = S_READ;
      end
      S_AREF:  if (flag_ref_end) w_next = S_ARBIT;
      S_WRITE: if (flag_wr_end)  w_next = S_ARBIT;
      S_READ:  if (flag_rd_end)  w_next = S_ARBIT;
      default: w_next = S_INIT;
    endcase
  end

  always_comb begin
    w_cmd        = c_NOP;
    sdram_addr   = '0;
    sdram_bank   = '0;
    sdram_dq_out = '0;
    case (r_state)
      S_INIT: begin
        w_cmd      = init_cmd;
        sdram_addr = init_addr;
      end
      S_AREF: begin
        w_cmd      = aref_cmd;
        sdram_addr = aref_addr;
      end
      S_WRITE: begin
        w_cmd        = wr_cmd;
        sdram_addr   = wr_addr;
        sdram_bank   = wr_bank;
        sdram_dq_out = wr_data;
      end
      S_READ: begin
        w_cmd      = rd_cmd;
        sdram_addr = rd_addr;
        sdram_bank = rd_bank;
      end
      default: ;
    endcase
  end

  assign w_grant     = (r_state == S_AREF) || (r_state == S_WRITE) || (r_state == S_READ);
  assign ref_en      = (r_state == S_AREF);
  assign wr_en       = (r_state == S_WRITE);
  assign rd_en       = (r_state == S_READ);
  assign sdram_dq_oe = (r_state == S_WRITE);
  assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = w_cmd;
  assign sdram_cke   = r_cke;
  assign err_timeout = r_err;

endmodule
`default_nettype wire

// File: tb/tb_sdram_arbit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_sdram_arbit                                                   |
// | Brief   : Directed self-checking bench for sdram_arbit.                    |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_sdram_arbit;

  localparam int DQ_W = 16;

  logic            sclk = 1'b0;
  logic            s_rst;
  logic [3:0]      init_cmd, aref_cmd, wr_cmd, rd_cmd;
  logic [12:0]     init_addr, aref_addr, wr_addr, rd_addr;
  logic [1:0]      wr_bank, rd_bank;
  logic [DQ_W-1:0] wr_data;
  logic            flag_init_end, flag_ref_end, flag_wr_end, flag_rd_end;
  logic            ref_req, wr_req, rd_req;
  logic            ref_en, wr_en, rd_en;
  logic            sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]      sdram_bank;
  logic [12:0]     sdram_addr;
  logic [DQ_W-1:0] sdram_dq_out;
  logic            sdram_dq_oe, err_timeout;
  logic [3:0]      w_pins;

  int n_checks = 0;
  int n_errors = 0;
  logic exp_w;

  assign w_pins = {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n};

  always #5 sclk = ~sclk;

  sdram_arbit #(.TIMEOUT_CYC(15), .DQ_W(DQ_W)) u_dut (
    .sclk(sclk), .s_rst(s_rst),
    .init_cmd(init_cmd), .init_addr(init_addr), .flag_init_end(flag_init_end),
    .ref_req(ref_req), .ref_en(ref_en), .aref_cmd(aref_cmd), .aref_addr(aref_addr),
    .flag_ref_end(flag_ref_end),
    .wr_req(wr_req), .wr_en(wr_en), .wr_cmd(wr_cmd), .wr_addr(wr_addr),
    .wr_bank(wr_bank), .wr_data(wr_data), .flag_wr_end(flag_wr_end),
    .rd_req(rd_req), .rd_en(rd_en), .rd_cmd(rd_cmd), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .flag_rd_end(flag_rd_end),
    .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
    .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_bank(sdram_bank),
    .sdram_addr(sdram_addr), .sdram_dq_out(sdram_dq_out), .sdram_dq_oe(sdram_dq_oe),
    .err_timeout(err_timeout)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_grants(input string tag, input logic r, input logic w, input logic d);
    chk(tag, {29'd0, ref_en, wr_en, rd_en}, {29'd0, r, w, d});
  endtask

  initial begin
    s_rst = 1'b1;
    init_cmd = 4'b0010;  init_addr = 13'h400;
    aref_cmd = 4'b0001;  aref_addr = 13'h011;
    wr_cmd   = 4'b0100;  wr_addr   = 13'h005; wr_bank = 2'd2; wr_data = 16'hA5A5;
    rd_cmd   = 4'b0101;  rd_addr   = 13'h0AB; rd_bank = 2'd1;
    {flag_init_end, flag_ref_end, flag_wr_end, flag_rd_end} = 4'b0000;
    {ref_req, wr_req, rd_req} = 3'b000;

    // Reset and init
    repeat (3) tick();
    chk("rst_cke", 32'(sdram_cke), 32'd0);
    chk("rst_pins", 32'(w_pins), 32'h2);
    chk("rst_addr", 32'(sdram_addr), 32'h400);
    chk_grants("rst_grants", 1'b0, 1'b0, 1'b0);
    chk("rst_oe_err", {30'd0, sdram_dq_oe, err_timeout}, 32'd0);
    s_rst = 1'b0;
    tick();
    chk("cke_on", 32'(sdram_cke), 32'd1);
    repeat (5) tick();
    chk("init_pins", 32'(w_pins), 32'h2);
    flag_init_end = 1'b1;
    tick();
    flag_init_end = 1'b0;
    chk("arbit_pins", 32'(w_pins), 32'h7);
    chk("arbit_addr", 32'(sdram_addr), 32'd0);

    // All three requests: refresh first, then write (tie), then read
    {ref_req, wr_req, rd_req} = 3'b111;
    tick();
    chk_grants("ref_first", 1'b1, 1'b0, 1'b0);
    ref_req = 1'b0;
    tick();
    chk("aref_pins", 32'(w_pins), 32'h1);
    chk("aref_addr", 32'(sdram_addr), 32'h011);
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    chk_grants("ref_gap", 1'b0, 1'b0, 1'b0);
    chk("ref_gap_pins", 32'(w_pins), 32'h7);
    tick();
    chk_grants("wr_after_ref", 1'b0, 1'b1, 1'b0);
    chk("wr_pins", 32'(w_pins), 32'h4);
    chk("wr_addr", 32'(sdram_addr), 32'h005);
    chk("wr_bank", 32'(sdram_bank), 32'd2);
    chk("wr_data", 32'(sdram_dq_out), 32'hA5A5);
    chk("wr_oe", 32'(sdram_dq_oe), 32'd1);
    flag_wr_end = 1'b1;
    tick();
    chk_grants("wr_gap", 1'b0, 1'b0, 1'b0);
    chk("wr_gap_oe", 32'(sdram_dq_oe), 32'd0);
    chk("wr_gap_data", 32'(sdram_dq_out), 32'd0);
    tick();  // stale flag_wr_end still high in S_ARBIT
    flag_wr_end = 1'b0;
    chk_grants("rd_after_wr", 1'b0, 1'b0, 1'b1);
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;
    chk_grants("rd_foreign_flag", 1'b0, 1'b0, 1'b1);
    chk("rd_pins", 32'(w_pins), 32'h5);
    chk("rd_addr", 32'(sdram_addr), 32'h0AB);
    chk("rd_bank", 32'(sdram_bank), 32'd1);
    chk("rd_oe", {31'd0, sdram_dq_oe}, 32'd0);
    flag_rd_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    chk_grants("rd_gap", 1'b0, 1'b0, 1'b0);

    // Round-robin alternation with both requests held
    for (int g = 0; g < 4; g++) begin
      exp_w = (g % 2 == 0);
      tick();
      chk_grants("alt_grant", 1'b0, exp_w, !exp_w);
      repeat (4) tick();
      chk_grants("alt_hold", 1'b0, exp_w, !exp_w);
      if (exp_w) flag_wr_end = 1'b1;
      else       flag_rd_end = 1'b1;
      tick();
      flag_wr_end = 1'b0;
      flag_rd_end = 1'b0;
      chk_grants("alt_nop", 1'b0, 1'b0, 1'b0);
      chk("alt_nop_pins", 32'(w_pins), 32'h7);
    end

    // No pre-emption: refresh request during a write waits for S_ARBIT
    rd_req = 1'b0;
    tick();
    chk_grants("pre_wr", 1'b0, 1'b1, 1'b0);
    ref_req = 1'b1;
    tick();
    chk_grants("no_preempt", 1'b0, 1'b1, 1'b0);
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    wr_req = 1'b0;
    chk_grants("pre_gap", 1'b0, 1'b0, 1'b0);
    tick();
    chk_grants("pre_ref", 1'b1, 1'b0, 1'b0);
    ref_req = 1'b0;
    flag_ref_end = 1'b1;
    tick();
    flag_ref_end = 1'b0;

    // Timeout: read held open with no end flag
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    chk_grants("tmo_rd", 1'b0, 1'b0, 1'b1);
    chk("tmo_c1", 32'(err_timeout), 32'd0);
    repeat (14) tick();
    chk("tmo_c15", 32'(err_timeout), 32'd0);
    tick();
    chk("tmo_c16", 32'(err_timeout), 32'd1);
    chk_grants("tmo_no_abort", 1'b0, 1'b0, 1'b1);
    flag_rd_end = 1'b1;
    tick();
    flag_rd_end = 1'b0;
    tick();
    chk("tmo_sticky", 32'(err_timeout), 32'd1);

    // Reset during a write
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    chk_grants("rst_pre_wr", 1'b0, 1'b1, 1'b0);
    s_rst = 1'b1;
    tick();
    chk_grants("rst_mid_grants", 1'b0, 1'b0, 1'b0);
    chk("rst_mid_oe", 32'(sdram_dq_oe), 32'd0);
    chk("rst_mid_err", 32'(err_timeout), 32'd0);
    chk("rst_mid_pins", 32'(w_pins), 32'h2);
    s_rst = 1'b0;
    flag_wr_end = 1'b1;
    tick();
    flag_wr_end = 1'b0;
    tick();
    chk("rst_late_flag", 32'(w_pins), 32'h2);
    chk_grants("rst_late_grants", 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
